sine_dac_sequencer: RTL and testbench

Sample sequencer for the 8-bit sine-wave DAC. It generates sine codes from a phase accumulator and a quarter-wave lookup table, and paces them to the DAC's `I_data`/`en` inputs at a programmable sample rate. It supports continuous or fixed-length bursts, with an orderly return to midscale on completion or stop. It sits between the control/register logic and the DAC model in the sine-wave bench.

---
 rtl/sine_dac_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_sine_dac_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sine_dac_sequencer.sv
// Sine-wave DAC sample sequencer: phase accumulator plus quarter-wave LUT, paced by a sample-period divider.
// Latency: the first sample is strobed one cycle after start is accepted; samples are then div+1 cycles apart.
// Backpressure: none; the DAC captures I_data whenever en is high. Stop and burst end park the output at midscale.
// Ports: clk/rst_n; start/stop requests; fcw/div/n_samples config (latched at start);
//        I_data/en DAC drive; busy (RUN or PARK); done (one-cycle pulse on the park strobe).
module sine_dac_sequencer #(
    parameter int DIV_W   = 16,
    parameter int PHASE_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [PHASE_W-1:0] fcw,
    input  logic [DIV_W-1:0]   div,
    input  logic [CNT_W-1:0]   n_samples,
    output logic [7:0]         I_data,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PARK = 2'd2
    } state_t;

    localparam logic [7:0] MIDSCALE = 8'd128;

    state_t             state_q, state_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] fcw_q, fcw_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   nsmp_q, nsmp_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]   scnt_inc;
    logic               pend_q, pend_d;
    logic [7:0]         data_q, data_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Quarter-wave table: round(127 * sin(2*pi*i/256)), i = 0..64.
    function automatic logic [6:0] qsin(input logic [6:0] i);
        logic [6:0] v;
        case (i)
            7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
            7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
            7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
            7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
            7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
            7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
            7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
            7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
            7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
            7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
            7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
            7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
            7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
            7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
            7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
            7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    // Phase to code: top 8 phase bits select quadrant and table index.
    // Odd quadrants read the table backwards, the lower half-cycle subtracts.
    logic [7:0] ph;
    logic [6:0] idx;
    logic [6:0] mag;
    logic [7:0] code;

    always_comb begin
        ph   = acc_q[PHASE_W-1 -: 8];
        idx  = ph[6] ? (7'd64 - {1'b0, ph[5:0]}) : {1'b0, ph[5:0]};
        mag  = qsin(idx);
        code = ph[7] ? (MIDSCALE - {1'b0, mag}) : (MIDSCALE + {1'b0, mag});
    end

    assign scnt_inc = scnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        fcw_d   = fcw_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        nsmp_d  = nsmp_q;
        scnt_d  = scnt_q;
        pend_d  = pend_q;
        data_d  = data_q;
        en_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) begin
                    fcw_d   = fcw;
                    div_d   = div;
                    nsmp_d  = n_samples;
                    acc_d   = '0;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    pend_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                pend_d = pend_q | stop;
                if (cnt_q == '0) begin
                    if (pend_q || stop) begin
                        // Pending stop or finished burst: this tick becomes the park strobe.
                        data_d  = MIDSCALE;
                        en_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_PARK;
                    end else begin
                        data_d = code;
                        en_d   = 1'b1;
                        acc_d  = acc_q + fcw_q;
                        cnt_d  = div_q;
                        scnt_d = scnt_inc;
                        // Last burst sample: park on the following tick, div+1 cycles later.
                        if (nsmp_q != '0 && scnt_inc == nsmp_q) begin
                            pend_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            ST_PARK: begin
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            fcw_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            nsmp_q  <= '0;
            scnt_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= MIDSCALE;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fcw_q   <= fcw_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            nsmp_q  <= nsmp_d;
            scnt_q  <= scnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign I_data = data_q;
    assign en     = en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sine_dac_sequencer.sv
// Directed bench for sine_dac_sequencer with hand-computed code sequences.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: none; strobe gaps are checked cycle by cycle.
module tb_sine_dac_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [15:0] fcw;
    logic [15:0] div;
    logic [15:0] n_samples;
    logic [7:0]  I_data;
    logic        en;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    sine_dac_sequencer #(
        .DIV_W  (16),
        .PHASE_W(16),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .fcw      (fcw),
        .div      (div),
        .n_samples(n_samples),
        .I_data   (I_data),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walks gap cycles from the current falling edge: the first gap-1 must be
    // strobe-free, the last must carry a strobe with the given code and done.
    task automatic expect_strobe(input string tag, input int gap,
                                 input logic [7:0] code, input logic exp_done);
        int spurious;
        spurious = 0;
        for (int i = 0; i < gap - 1; i++) begin
            @(negedge clk);
            if (en) spurious++;
        end
        @(negedge clk);
        chk({tag, " quiet"}, spurious, 0);
        chk({tag, " en"}, en, 1);
        chk({tag, " code"}, I_data, code);
        chk({tag, " done"}, done, exp_done);
    endtask

    // Start is applied for one cycle; the first strobe (phase 0) follows one cycle later.
    task automatic do_start(input string tag, input logic [15:0] f, input logic [15:0] d,
                            input logic [15:0] n);
        fcw       = f;
        div       = d;
        n_samples = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        expect_strobe({tag, " s0"}, 1, 8'd128, 1'b0);
        chk({tag, " busy"}, busy, 1);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " en"}, en, 0);
        chk({tag, " done"}, done, 0);
    endtask

    logic [7:0] quad_codes [0:3];
    logic [7:0] mid_codes  [0:7];

    initial begin
        quad_codes = '{8'd128, 8'd255, 8'd128, 8'd1};
        mid_codes  = '{8'd128, 8'd218, 8'd255, 8'd218, 8'd128, 8'd38, 8'd1, 8'd38};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        fcw = '0; div = '0; n_samples = '0;
        repeat (3) @(negedge clk);
        chk("rst I_data", I_data, 128);
        expect_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Quadrant points, continuous, div=3; start pulse mid-run must not restart.
        do_start("quad", 16'h4000, 16'd3, 16'd0);
        for (int i = 1; i < 6; i++) expect_strobe("quad", 4, quad_codes[i % 4], 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_strobe("quad nostart", 3, 8'd128, 1'b0);
        expect_strobe("quad nostart", 4, 8'd1, 1'b0);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst I_data", I_data, 128);
        expect_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // LUT midpoints at div=0: a strobe every cycle.
        do_start("mid", 16'h2000, 16'd0, 16'd0);
        for (int i = 1; i < 8; i++) expect_strobe("mid", 1, mid_codes[i], 1'b0);
        expect_strobe("mid wrap", 1, 8'd128, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stop 3 cycles after a strobe at div=9: park strobe 7 cycles later.
        do_start("stop", 16'h4000, 16'd9, 16'd0);
        expect_strobe("stop", 10, 8'd255, 1'b0);
        repeat (3) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        expect_strobe("stop park", 6, 8'd128, 1'b1);
        @(negedge clk);
        expect_idle("stop after");
        repeat (12) @(negedge clk);
        chk("stop stays idle", busy, 0);

        // Burst of 4 at div=1, run twice from phase 0.
        for (int r = 0; r < 2; r++) begin
            do_start("burst", 16'h4000, 16'd1, 16'd4);
            for (int i = 1; i < 4; i++) expect_strobe("burst", 2, quad_codes[i], 1'b0);
            expect_strobe("burst park", 2, 8'd128, 1'b1);
            chk("burst park busy", busy, 1);
            @(negedge clk);
            expect_idle("burst after");
            @(negedge clk);
        end

        // Simultaneous start and stop in IDLE: nothing happens.
        fcw = 16'h4000; div = 16'd0; n_samples = 16'd0;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        expect_idle("startstop");
        repeat (3) @(negedge clk);
        expect_idle("startstop later");

        // fcw=0 burst of 3 at div=2: midscale strobes, then the park strobe.
        do_start("zero", 16'h0000, 16'd2, 16'd3);
        expect_strobe("zero", 3, 8'd128, 1'b0);
        expect_strobe("zero", 3, 8'd128, 1'b0);
        expect_strobe("zero park", 3, 8'd128, 1'b1);
        @(negedge clk);
        expect_idle("zero after");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
